// File: rtl/alu_sequencer.sv
// Command sequencer for the shared register-file/ALU datapath.
// Buffers load/ALU commands in a FIFO and issues each one over one (load) or two (ALU) cycles.
module alu_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     cmdValid,
  output logic                     cmdReady,
  input  logic                     cmdKind,
  input  logic [3:0]               cmdOp,
  input  logic [4:0]               cmdRd,
  input  logic [4:0]               cmdRs1,
  input  logic [4:0]               cmdRs2,
  input  logic [4:0]               cmdShamt,
  input  logic                     cmdWb,
  input  logic [31:0]              cmdData,
  output logic                     wrEnable,
  output logic [4:0]               wrReg,
  output logic [4:0]               rdReg1,
  output logic [4:0]               rdReg2,
  output logic [3:0]               opCode,
  output logic [4:0]               shiftAmt,
  output logic                     selCh,
  output logic [31:0]              selData,
  input  logic [31:0]              aluResult,
  output logic                     doneValid,
  output logic [4:0]               doneRd,
  output logic [31:0]              doneResult,
  output logic                     errPulse,
  output logic [$clog2(DEPTH):0]   fifoCount
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic        kind;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  shamt;
    logic        wb;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WRITE} state_t;

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ready;
  state_t        r_state;
  cmd_t          r_cur;

  logic          r_wr_en, r_sel_ch, r_done_v, r_err;
  logic [4:0]    r_wr_reg, r_rd1, r_rd2, r_sh, r_done_rd;
  logic [3:0]    r_op;
  logic [31:0]   r_sel_data, r_done_res;

  logic          w_push, w_pop, w_dispatch;
  logic [CW-1:0] w_count_nxt;
  cmd_t          w_cmd_in, w_head, w_cur_nxt;
  state_t        w_state_nxt;
  logic          w_wr_en, w_sel_ch, w_done_v, w_err;
  logic [4:0]    w_wr_reg, w_rd1, w_rd2, w_sh, w_done_rd;
  logic [3:0]    w_op;
  logic [31:0]   w_sel_data, w_done_res;

  assign w_cmd_in = '{kind: cmdKind, op: cmdOp, rd: cmdRd, rs1: cmdRs1, rs2: cmdRs2,
                      shamt: cmdShamt, wb: cmdWb, data: cmdData};
  assign w_push      = cmdValid && r_ready;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // FIFO storage carries no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_cmd_in;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  // Next state and next registered outputs; IDLE and WRITE both dispatch the FIFO head
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    w_dispatch  = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_reg    = '0;
    w_rd1       = '0;
    w_rd2       = '0;
    w_op        = '0;
    w_sh        = '0;
    w_sel_ch    = 1'b0;
    w_sel_data  = '0;
    w_done_v    = 1'b0;
    w_done_rd   = '0;
    w_done_res  = '0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: w_dispatch = 1'b1;
      S_ISSUE: begin
        w_state_nxt = S_WRITE;
        w_wr_en     = r_cur.wb;
        w_sel_ch    = 1'b1;
        w_wr_reg    = r_cur.rd;
        w_rd1       = r_cur.rs1;
        w_rd2       = r_cur.rs2;
        w_op        = r_cur.op;
        w_sh        = r_cur.shamt;
      end
      S_WRITE: begin
        w_state_nxt = S_IDLE;
        w_done_v    = 1'b1;
        w_done_rd   = r_cur.rd;
        w_done_res  = r_cur.kind ? r_cur.data : aluResult;
        w_dispatch  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_dispatch && (r_count != '0)) begin
      w_pop     = 1'b1;
      w_cur_nxt = w_head;
      if (w_head.kind) begin
        w_state_nxt = S_WRITE;
        w_wr_en     = 1'b1;
        w_wr_reg    = w_head.rd;
        w_sel_data  = w_head.data;
      end else if (w_head.op <= 4'd8) begin
        w_state_nxt = S_ISSUE;
        w_wr_reg    = w_head.rd;
        w_rd1       = w_head.rs1;
        w_rd2       = w_head.rs2;
        w_op        = w_head.op;
        w_sh        = w_head.shamt;
      end else begin
        w_state_nxt = S_IDLE;
        w_err       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state    <= S_IDLE;
      r_cur      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_reg   <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_op       <= '0;
      r_sh       <= '0;
      r_sel_ch   <= 1'b0;
      r_sel_data <= '0;
      r_done_v   <= 1'b0;
      r_done_rd  <= '0;
      r_done_res <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_wr_en    <= w_wr_en;
      r_wr_reg   <= w_wr_reg;
      r_rd1      <= w_rd1;
      r_rd2      <= w_rd2;
      r_op       <= w_op;
      r_sh       <= w_sh;
      r_sel_ch   <= w_sel_ch;
      r_sel_data <= w_sel_data;
      r_done_v   <= w_done_v;
      r_done_rd  <= w_done_rd;
      r_done_res <= w_done_res;
      r_err      <= w_err;
    end
  end

  assign cmdReady   = r_ready;
  assign fifoCount  = r_count;
  assign wrEnable   = r_wr_en;
  assign wrReg      = r_wr_reg;
  assign rdReg1     = r_rd1;
  assign rdReg2     = r_rd2;
  assign opCode     = r_op;
  assign shiftAmt   = r_sh;
  assign selCh      = r_sel_ch;
  assign selData    = r_sel_data;
  assign doneValid  = r_done_v;
  assign doneRd     = r_done_rd;
  assign doneResult = r_done_res;
  assign errPulse   = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a register-file/ALU datapath model attached.
module tb_alu_sequencer;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cmdValid, cmdReady, cmdKind, cmdWb;
  logic [3:0]  cmdOp;
  logic [4:0]  cmdRd, cmdRs1, cmdRs2, cmdShamt;
  logic [31:0] cmdData;
  logic        wrEnable, selCh, doneValid, errPulse;
  logic [4:0]  wrReg, rdReg1, rdReg2, shiftAmt, doneRd;
  logic [3:0]  opCode;
  logic [31:0] selData, aluResult, doneResult;
  logic [$clog2(DEPTH):0] fifoCount;

  alu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdKind(cmdKind), .cmdOp(cmdOp), .cmdRd(cmdRd), .cmdRs1(cmdRs1), .cmdRs2(cmdRs2),
    .cmdShamt(cmdShamt), .cmdWb(cmdWb), .cmdData(cmdData),
    .wrEnable(wrEnable), .wrReg(wrReg), .rdReg1(rdReg1), .rdReg2(rdReg2),
    .opCode(opCode), .shiftAmt(shiftAmt), .selCh(selCh), .selData(selData),
    .aluResult(aluResult), .doneValid(doneValid), .doneRd(doneRd),
    .doneResult(doneResult), .errPulse(errPulse), .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  // Datapath: register file written on the clock edge, combinational signed ALU
  logic [31:0] rf [32] = '{default: 32'd0};
  logic signed [31:0] alu_a, alu_b;

  always @(posedge clk) begin
    if (wrEnable) rf[wrReg] <= selCh ? aluResult : selData;
  end

  always_comb begin
    alu_a = rf[rdReg1];
    alu_b = rf[rdReg2];
    case (opCode)
      4'd0:    aluResult = alu_a + alu_b;
      4'd1:    aluResult = alu_a - alu_b;
      4'd2:    aluResult = alu_a & alu_b;
      4'd3:    aluResult = alu_a | alu_b;
      4'd4:    aluResult = alu_a << shiftAmt;
      4'd5:    aluResult = 32'(unsigned'(alu_a) >> shiftAmt);
      4'd6:    aluResult = alu_a >>> shiftAmt;
      4'd7:    aluResult = (alu_a > alu_b) ? 32'd1 : 32'd0;
      4'd8:    aluResult = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: aluResult = 32'd0;
    endcase
  end

  // Observation of completions, error pulses, writes and ready/count coherence
  logic [4:0]  done_rd_q [$];
  logic [31:0] done_res_q [$];
  int   err_cnt   = 0;
  int   wr_cnt    = 0;
  int   ready_bad = 0;
  logic full_seen = 1'b0;

  always @(negedge clk) begin
    if (doneValid) begin
      done_rd_q.push_back(doneRd);
      done_res_q.push_back(doneResult);
    end
    if (errPulse) err_cnt++;
    if (wrEnable) wr_cnt++;
    if (cmdReady != (fifoCount != ($clog2(DEPTH)+1)'(DEPTH))) ready_bad++;
    if (fifoCount == ($clog2(DEPTH)+1)'(DEPTH)) full_seen = 1'b1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic push_cmd(input logic kind, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] sh,
                          input logic wb, input logic [31:0] data);
    int budget = 0;
    cmdKind = kind; cmdOp = op; cmdRd = rd; cmdRs1 = rs1; cmdRs2 = rs2;
    cmdShamt = sh; cmdWb = wb; cmdData = data; cmdValid = 1'b1;
    while (!cmdReady && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("push_ready_timeout", 32'(cmdReady), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int budget = 0;
    while (done_res_q.size() < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    check("done_count", 32'(done_res_q.size()), 32'(n));
  endtask

  task automatic pop_check(input string tag, input logic [4:0] exp_rd, input logic [31:0] exp_res);
    check({tag, "_present"}, 32'(done_res_q.size() > 0), 32'd1);
    if (done_res_q.size() > 0) begin
      check({tag, "_rd"}, 32'(done_rd_q.pop_front()), 32'(exp_rd));
      check({tag, "_res"}, done_res_q.pop_front(), exp_res);
    end
  endtask

  int w0, e0;

  initial begin
    rstN = 1'b0; cmdValid = 1'b0; cmdKind = 1'b0; cmdOp = '0; cmdRd = '0;
    cmdRs1 = '0; cmdRs2 = '0; cmdShamt = '0; cmdWb = 1'b0; cmdData = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmdReady), 32'd1);
    check("rst_count", 32'(fifoCount), 32'd0);
    check("rst_we", 32'(wrEnable), 32'd0);
    check("rst_done", 32'(doneValid), 32'd0);
    check("rst_err", 32'(errPulse), 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // Load latency: WRITE one cycle after the push, done the cycle after that
    push_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd1);
    check("ld_n_we", 32'(wrEnable), 32'd0);
    check("ld_n_count", 32'(fifoCount), 32'd1);
    @(negedge clk);
    check("ld_n1_we", 32'(wrEnable), 32'd1);
    check("ld_n1_seldata", selData, 32'd1);
    check("ld_n1_selch", 32'(selCh), 32'd0);
    check("ld_n1_done", 32'(doneValid), 32'd0);
    @(negedge clk);
    check("ld_n2_done", 32'(doneValid), 32'd1);
    check("ld_n2_res", doneResult, 32'd1);
    wait_done(1);
    pop_check("ld_r0", 5'd0, 32'd1);

    // Loads, dependent add, back-to-back RAW add
    push_cmd(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd7);
    push_cmd(1'b0, 4'd0, 5'd2, 5'd0, 5'd1, 5'd0, 1'b1, 32'd0);
    push_cmd(1'b0, 4'd0, 5'd3, 5'd2, 5'd0, 5'd0, 1'b1, 32'd0);
    wait_done(3);
    pop_check("ld_r1", 5'd1, 32'd7);
    pop_check("add_r2", 5'd2, 32'd8);
    pop_check("raw_r3", 5'd3, 32'd9);
    check("rf_r3", rf[3], 32'd9);

    // Report-only ops never write
    push_cmd(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
    wait_done(1);
    pop_check("ld_r1_zero", 5'd1, 32'd0);
    w0 = wr_cnt;
    push_cmd(1'b0, 4'd1, 5'd4, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd2, 5'd4, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd3, 5'd4, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    wait_done(3);
    pop_check("sub", 5'd4, 32'd1);
    pop_check("and", 5'd4, 32'd0);
    pop_check("or", 5'd4, 32'd1);
    check("wb0_no_write", 32'(wr_cnt - w0), 32'd0);
    check("rf_r4", rf[4], 32'd0);

    // Signed shifts and compares
    push_cmd(1'b1, 4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFF7);
    push_cmd(1'b1, 4'd0, 5'd1, 5'd0, 5'd0, 5'd0, 1'b0, 32'd7);
    wait_done(2);
    pop_check("ld_neg9", 5'd0, 32'hFFFF_FFF7);
    pop_check("ld_7", 5'd1, 32'd7);
    push_cmd(1'b0, 4'd6, 5'd9, 5'd0, 5'd0, 5'd1, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd5, 5'd9, 5'd0, 5'd0, 5'd2, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd7, 5'd9, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd8, 5'd9, 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    push_cmd(1'b0, 4'd4, 5'd9, 5'd0, 5'd0, 5'd4, 1'b0, 32'd0);
    wait_done(5);
    pop_check("sra", 5'd9, 32'hFFFF_FFFB);
    pop_check("srl", 5'd9, 32'h3FFF_FFFD);
    pop_check("gt", 5'd9, 32'd0);
    pop_check("lt", 5'd9, 32'd1);
    pop_check("sll", 5'd9, 32'hFFFF_FF70);

    // Sustained ALU pushes fill the FIFO; order and count preserved
    for (int i = 0; i < 10; i++)
      push_cmd(1'b0, 4'd0, 5'(10 + i), 5'd0, 5'd1, 5'd0, 1'b0, 32'd0);
    wait_done(10);
    for (int i = 0; i < 10; i++)
      pop_check($sformatf("fill%0d", i), 5'(10 + i), 32'hFFFF_FFFE);
    check("fill_full_seen", 32'(full_seen), 32'd1);
    check("ready_vs_count", 32'(ready_bad), 32'd0);

    // Illegal opcode between two loads
    e0 = err_cnt;
    w0 = wr_cnt;
    push_cmd(1'b1, 4'd0, 5'd6, 5'd0, 5'd0, 5'd0, 1'b0, 32'h66);
    push_cmd(1'b0, 4'd12, 5'd8, 5'd0, 5'd1, 5'd0, 1'b1, 32'hDEAD);
    push_cmd(1'b1, 4'd0, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 32'h77);
    wait_done(2);
    pop_check("ld_r6", 5'd6, 32'h66);
    pop_check("ld_r7", 5'd7, 32'h77);
    check("bad_err_once", 32'(err_cnt - e0), 32'd1);
    check("bad_writes", 32'(wr_cnt - w0), 32'd2);
    check("bad_rf_r8", rf[8], 32'd0);

    // Reset during a load WRITE cancels the write
    push_cmd(1'b1, 4'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 32'h1111);
    wait_done(1);
    pop_check("ld_r5_old", 5'd5, 32'h1111);
    push_cmd(1'b1, 4'd0, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 32'hAAAA);
    @(negedge clk);
    check("rstw_we_before", 32'(wrEnable), 32'd1);
    rstN = 1'b0;
    #1;
    check("rstw_we", 32'(wrEnable), 32'd0);
    check("rstw_seldata", selData, 32'd0);
    check("rstw_wrreg", 32'(wrReg), 32'd0);
    check("rstw_count", 32'(fifoCount), 32'd0);
    check("rstw_ready", 32'(cmdReady), 32'd1);
    check("rstw_done", 32'(doneValid), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    check("rstw_r5_kept", rf[5], 32'h1111);
    check("rstw_no_done", 32'(done_res_q.size()), 32'd0);
    push_cmd(1'b1, 4'd0, 5'd20, 5'd0, 5'd0, 5'd0, 1'b0, 32'h5A);
    push_cmd(1'b0, 4'd0, 5'd21, 5'd0, 5'd1, 5'd0, 1'b1, 32'd0);
    wait_done(2);
    pop_check("post_ld", 5'd20, 32'h5A);
    pop_check("post_add", 5'd21, 32'hFFFF_FFFE);
    check("post_rf_r21", rf[21], 32'hFFFF_FFFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
